// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared state type, timing defaults and SCAN mask helpers
package elevator_pkg;

  localparam int MAX_FLOORS        = 16;
  localparam int DEF_TRAVEL_CYCLES = 100;
  localparam int DEF_DOOR_CYCLES   = 50;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2,
    HALT = 2'd3
  } state_e;

  function automatic logic [MAX_FLOORS-1:0] above_mask(input logic [3:0] f);
    logic [MAX_FLOORS-1:0] m;
    for (int i = 0; i < MAX_FLOORS; i++) m[i] = (i > int'(f));
    return m;
  endfunction

  function automatic logic [MAX_FLOORS-1:0] below_mask(input logic [3:0] f);
    logic [MAX_FLOORS-1:0] m;
    for (int i = 0; i < MAX_FLOORS; i++) m[i] = (i < int'(f));
    return m;
  endfunction

endpackage

// File: rtl/elevator_if.sv
// rtl/elevator_if.sv - request/status bundle between buttons, controller and motor/door drivers
interface elevator_if #(
  parameter int N_FLOORS = 8,
  parameter int FLOOR_W  = $clog2(N_FLOORS)
);

  logic [N_FLOORS-1:0] req;
  logic                door_hold;
  logic                estop;
  logic [FLOOR_W-1:0]  floor;
  logic [N_FLOORS-1:0] pending;
  logic                motor_up;
  logic                motor_down;
  logic                door_open;
  logic                dir_up;
  logic                arrive;
  logic                busy;

  modport master (
    output req, door_hold, estop,
    input  floor, pending, motor_up, motor_down, door_open, dir_up, arrive, busy
  );

  modport slave (
    input  req, door_hold, estop,
    output floor, pending, motor_up, motor_down, door_open, dir_up, arrive, busy
  );

endinterface

// File: rtl/elevator_timer.sv
// rtl/elevator_timer.sv - loadable down-counter shared by floor travel and door dwell
module elevator_timer #(
  parameter int TIMER_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               clear,
  output logic               done
);

  logic [TIMER_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear)               count_d = '0;
    else if (load)           count_d = load_val;
    else if (count_q != '0)  count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/elevator_scheduler.sv
// rtl/elevator_scheduler.sv - single-car SCAN elevator controller with door dwell and emergency stop
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int N_FLOORS      = 8,
  parameter int FLOOR_W       = $clog2(N_FLOORS),
  parameter int TRAVEL_CYCLES = DEF_TRAVEL_CYCLES,
  parameter int DOOR_CYCLES   = DEF_DOOR_CYCLES,
  parameter int TIMER_W       = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  elevator_if.slave  bus
);

  localparam logic [TIMER_W-1:0] TRAVEL_LOAD = TIMER_W'(TRAVEL_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DOOR_LOAD   = TIMER_W'(DOOR_CYCLES - 1);

  state_e              state_q, state_d;
  logic [FLOOR_W-1:0]  floor_q, floor_d, next_floor;
  logic [N_FLOORS-1:0] pending_q, pending_d, clr;
  logic                dir_up_q, dir_up_d;
  logic                arrive_q, arrive_d;
  logic                halt_door_q, halt_door_d;

  logic                t_load, t_clear, t_done;
  logic [TIMER_W-1:0]  t_load_val;

  logic [MAX_FLOORS-1:0] pend_ext;
  logic above, below, above_next, below_next;
  logic pend_here, pend_next, req_here;

  assign pend_ext   = MAX_FLOORS'(pending_q);
  assign next_floor = dir_up_q ? floor_q + 1'b1 : floor_q - 1'b1;
  assign above      = |(pend_ext & above_mask(4'(floor_q)));
  assign below      = |(pend_ext & below_mask(4'(floor_q)));
  assign above_next = |(pend_ext & above_mask(4'(next_floor)));
  assign below_next = |(pend_ext & below_mask(4'(next_floor)));
  assign pend_here  = pending_q[floor_q];
  assign pend_next  = pending_q[next_floor];
  assign req_here   = bus.req[floor_q];

  elevator_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (t_load),
    .load_val (t_load_val),
    .clear    (t_clear),
    .done     (t_done)
  );

  always_comb begin
    state_d     = state_q;
    floor_d     = floor_q;
    dir_up_d    = dir_up_q;
    arrive_d    = 1'b0;
    halt_door_d = halt_door_q;
    t_load      = 1'b0;
    t_load_val  = TRAVEL_LOAD;
    t_clear     = 1'b0;
    clr         = '0;

    if (bus.estop) begin
      state_d = HALT;
      t_clear = 1'b1;
      if (state_q != HALT) halt_door_d = (state_q == DOOR);
    end else begin
      case (state_q)
        IDLE: begin
          if (pend_here) begin
            state_d    = DOOR;
            t_load     = 1'b1;
            t_load_val = DOOR_LOAD;
          end else if (above || below) begin
            state_d = MOVE;
            t_load  = 1'b1;
            // Reverse only when nothing remains in the current sweep direction.
            if (!(dir_up_q ? above : below)) dir_up_d = above;
          end
        end
        MOVE: begin
          if (t_done) begin
            floor_d  = next_floor;
            arrive_d = 1'b1;
            if (pend_next) begin
              state_d    = DOOR;
              t_load     = 1'b1;
              t_load_val = DOOR_LOAD;
            end else if (dir_up_q ? above_next : below_next) begin
              t_load = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
        DOOR: begin
          if (bus.door_hold || req_here) begin
            t_load     = 1'b1;
            t_load_val = DOOR_LOAD;
          end else if (t_done) begin
            state_d = IDLE;
          end
        end
        HALT: begin
          state_d     = IDLE;
          halt_door_d = 1'b0;
        end
      endcase
    end

    // The served floor is cleared on entry to and throughout the dwell, winning over a new req.
    if (state_q == DOOR || state_d == DOOR) clr = N_FLOORS'(1) << floor_d;
    pending_d = (pending_q | bus.req) & ~clr;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      floor_q     <= '0;
      pending_q   <= '0;
      dir_up_q    <= 1'b1;
      arrive_q    <= 1'b0;
      halt_door_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      floor_q     <= floor_d;
      pending_q   <= pending_d;
      dir_up_q    <= dir_up_d;
      arrive_q    <= arrive_d;
      halt_door_q <= halt_door_d;
    end
  end

  assign bus.floor      = floor_q;
  assign bus.pending    = pending_q;
  assign bus.dir_up     = dir_up_q;
  assign bus.arrive     = arrive_q;
  assign bus.motor_up   = (state_q == MOVE) && dir_up_q;
  assign bus.motor_down = (state_q == MOVE) && !dir_up_q;
  assign bus.door_open  = (state_q == DOOR) || ((state_q == HALT) && halt_door_q);
  assign bus.busy       = (state_q != IDLE) || (pending_q != '0);

endmodule

// File: tb/tb_elevator_scheduler.sv
// tb/tb_elevator_scheduler.sv - scoreboard bench for elevator_scheduler against a floor-level SCAN model
module tb_elevator_scheduler;

  localparam int NF = 8;
  localparam int TC = 4;
  localparam int DC = 3;

  typedef enum {M_IDLE, M_MOVE, M_DOOR, M_HALT} mode_t;

  typedef struct packed {
    logic [2:0] floor;
    logic [7:0] pending;
    logic       motor_up;
    logic       motor_down;
    logic       door_open;
    logic       dir_up;
    logic       arrive;
    logic       busy;
  } snap_t;

  logic clk = 1'b0;
  logic reset_n;

  elevator_if #(.N_FLOORS(NF)) bus ();

  elevator_scheduler #(
    .N_FLOORS      (NF),
    .TRAVEL_CYCLES (TC),
    .DOOR_CYCLES   (DC),
    .TIMER_W       (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  snap_t exp_q[$];
  int    arr_q[$];

  // Reference car: cycles left in the current floor step or dwell, plus a request set.
  mode_t m_mode;
  int    m_floor;
  bit    m_up;
  int    m_left;
  bit    m_halt_door;
  bit    m_arrive;
  bit    m_pend[NF];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit work_above(input int f);
    for (int i = f + 1; i < NF; i++) if (m_pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit work_below(input int f);
    for (int i = 0; i < f; i++) if (m_pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_floor = 0; m_up = 1'b1; m_left = 0;
    m_halt_door = 1'b0; m_arrive = 1'b0;
    for (int i = 0; i < NF; i++) m_pend[i] = 1'b0;
  endtask

  task automatic start_travel();
    m_mode = M_MOVE;
    m_left = TC;
  endtask

  task automatic model_step(input logic [7:0] r, input bit h, input bit e);
    mode_t was;
    bit    ahead;
    was      = m_mode;
    m_arrive = 1'b0;
    if (e) begin
      if (m_mode != M_HALT) m_halt_door = (m_mode == M_DOOR);
      m_mode = M_HALT;
      m_left = 0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (m_pend[m_floor]) begin
            m_mode = M_DOOR; m_left = DC;
          end else if (m_up && work_above(m_floor)) start_travel();
          else if (!m_up && work_below(m_floor))    start_travel();
          else if (work_above(m_floor)) begin m_up = 1'b1; start_travel(); end
          else if (work_below(m_floor)) begin m_up = 1'b0; start_travel(); end
        end
        M_MOVE: begin
          m_left--;
          if (m_left == 0) begin
            m_floor  = m_up ? m_floor + 1 : m_floor - 1;
            m_arrive = 1'b1;
            arr_q.push_back(m_floor);
            ahead = m_up ? work_above(m_floor) : work_below(m_floor);
            if (m_pend[m_floor]) begin m_mode = M_DOOR; m_left = DC; end
            else if (ahead) m_left = TC;
            else m_mode = M_IDLE;
          end
        end
        M_DOOR: begin
          if (h || r[m_floor]) m_left = DC;
          else begin
            m_left--;
            if (m_left == 0) m_mode = M_IDLE;
          end
        end
        M_HALT: begin
          m_mode = M_IDLE;
          m_halt_door = 1'b0;
        end
      endcase
    end
    for (int i = 0; i < NF; i++) m_pend[i] = m_pend[i] | r[i];
    if (was == M_DOOR || m_mode == M_DOOR) m_pend[m_floor] = 1'b0;
  endtask

  function automatic snap_t model_snap();
    snap_t      s;
    logic [7:0] p;
    for (int i = 0; i < NF; i++) p[i] = m_pend[i];
    s.floor      = 3'(m_floor);
    s.pending    = p;
    s.motor_up   = (m_mode == M_MOVE) && m_up;
    s.motor_down = (m_mode == M_MOVE) && !m_up;
    s.door_open  = (m_mode == M_DOOR) || ((m_mode == M_HALT) && m_halt_door);
    s.dir_up     = m_up;
    s.arrive     = m_arrive;
    s.busy       = (m_mode != M_IDLE) || (p != 8'h00);
    return s;
  endfunction

  task automatic drive(input logic [7:0] r, input bit h, input bit e);
    @(negedge clk);
    bus.req = r; bus.door_hold = h; bus.estop = e;
    model_step(r, h, e);
    exp_q.push_back(model_snap());
  endtask

  task automatic idle(input int n);
    repeat (n) drive(8'h00, 1'b0, 1'b0);
  endtask

  task automatic run_until_door(input int limit);
    int n = 0;
    while (m_mode != M_DOOR && n < limit) begin
      drive(8'h00, 1'b0, 1'b0);
      n++;
    end
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_floor",   32'(bus.floor), 32'd0);
    chk("rst_pending", 32'(bus.pending), 32'd0);
    chk("rst_motors",  32'({bus.motor_up, bus.motor_down}), 32'd0);
    chk("rst_door",    32'(bus.door_open), 32'd0);
    chk("rst_arrive",  32'(bus.arrive), 32'd0);
    chk("rst_dir_up",  32'(bus.dir_up), 32'd1);
    model_reset();
    bus.req = '0; bus.door_hold = 1'b0; bus.estop = 1'b0;
    #1 reset_n = 1'b1;
    model_step(8'h00, 1'b0, 1'b0);
    exp_q.push_back(model_snap());
  endtask

  initial begin
    snap_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("floor",      32'(bus.floor),      32'(e.floor));
        chk("pending",    32'(bus.pending),    32'(e.pending));
        chk("motor_up",   32'(bus.motor_up),   32'(e.motor_up));
        chk("motor_down", 32'(bus.motor_down), 32'(e.motor_down));
        chk("door_open",  32'(bus.door_open),  32'(e.door_open));
        chk("dir_up",     32'(bus.dir_up),     32'(e.dir_up));
        chk("arrive",     32'(bus.arrive),     32'(e.arrive));
        chk("busy",       32'(bus.busy),       32'(e.busy));
      end
      if (bus.arrive === 1'b1) begin
        if (arr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL arrive_unexpected actual=floor %0d expected=no arrival at %0t", bus.floor, $time);
        end else begin
          chk("arrive_floor", 32'(bus.floor), 32'(arr_q.pop_front()));
        end
      end
    end
  end

  initial begin
    int est_cnt;
    logic [7:0] r;
    bit h;
    reset_n = 1'b0;
    bus.req = '0; bus.door_hold = 1'b0; bus.estop = 1'b0;
    model_reset();
    exp_q.push_back(model_snap());
    #7 reset_n = 1'b1;

    // Single trip 0 -> 3, dwell, back to idle.
    drive(8'h08, 1'b0, 1'b0);
    idle(30);
    // SCAN ordering: floor 1 requested while sweeping up toward 6.
    drive(8'h40, 1'b0, 1'b0);
    idle(12);
    drive(8'h02, 1'b0, 1'b0);
    idle(80);
    // Door hold and same-floor re-request at floor 2.
    drive(8'h04, 1'b0, 1'b0);
    run_until_door(100);
    repeat (5) drive(8'h00, 1'b1, 1'b0);
    drive(8'h00, 1'b0, 1'b0);
    drive(8'h04, 1'b0, 1'b0);
    idle(20);
    // Asynchronous reset while travelling.
    drive(8'h80, 1'b0, 1'b0);
    idle(6);
    async_reset();
    // Emergency stop mid-travel toward floor 4, new request latched during the stop.
    drive(8'h10, 1'b0, 1'b0);
    idle(7);
    repeat (2) drive(8'h00, 1'b0, 1'b1);
    drive(8'h80, 1'b0, 1'b1);
    drive(8'h00, 1'b0, 1'b1);
    idle(80);
    // Same-floor and far-floor request together from idle at floor 0.
    async_reset();
    drive(8'h81, 1'b0, 1'b0);
    idle(60);

    est_cnt = 0;
    for (int c = 0; c < 1500; c++) begin
      r = 8'h00;
      if ($urandom_range(0, 9) == 0) r = 8'(1 << $urandom_range(0, 7));
      else if ($urandom_range(0, 39) == 0) r = 8'($urandom_range(0, 255));
      h = ($urandom_range(0, 19) == 0);
      if (est_cnt > 0) est_cnt--;
      else if ($urandom_range(0, 99) == 0) est_cnt = $urandom_range(1, 5);
      drive(r, h, est_cnt > 0);
    end
    idle(200);
    @(negedge clk);
    @(negedge clk);
    chk("arrivals_outstanding", 32'(arr_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/elevator_scheduler.md
# elevator_scheduler

Parametrised single-car elevator controller: latches floor requests into a pending bitmap, tracks car position internally and serves requests in SCAN order (continue in current direction while work remains ahead, then reverse). It adds per-floor travel timing, door-hold/re-open and emergency stop. It sits between the request buttons and the motor/door drivers.

## Interface
- N_FLOORS, 8: number of floors, 2..16
- FLOOR_W, $clog2(N_FLOORS): floor index width
- TRAVEL_CYCLES, 100: cycles to travel one floor, ≥2
- DOOR_CYCLES, 50: door-open dwell cycles, ≥2
- TIMER_W, 8: timer width; must hold max(TRAVEL_CYCLES, DOOR_CYCLES)
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req  in  N_FLOORS  request pulses, one bit per floor; multiple bits allowed
- door_hold  in  1  level; keeps door open while high in DOOR
- estop  in  1  level; emergency stop
- floor  out  FLOOR_W  current car floor
- pending  out  N_FLOORS  latched unserved requests
- motor_up  out  1  drive up
- motor_down  out  1  drive down
- door_open  out  1  door open
- dir_up  out  1  SCAN direction, 1 = up
- arrive  out  1  one-cycle pulse on reaching a floor
- busy  out  1  state != IDLE or pending != 0

## Operation
- Reset (async on reset_n low): state IDLE, floor 0, pending 0, dir_up 1, timer 0, all motor/door/arrive outputs 0.
- States: IDLE, MOVE, DOOR, HALT.
- Request latch each edge: pending <= (pending | req) & ~clr. clr = bit of current floor when entering DOOR, and throughout DOOR. A req for the current floor while in DOOR extends the dwell and is never latched.
- above = |pending[N-1:floor+1]; below = |pending[floor-1:0].
- IDLE, in priority order: pending[floor] -> DOOR. Else dir_up & above -> MOVE up. Else !dir_up & below -> MOVE down. Else above -> dir_up<=1, MOVE. Else below -> dir_up<=0, MOVE. Else stay.
- MOVE: timer loaded TRAVEL_CYCLES-1, decrements; at 0: floor ±1, arrive=1 for that cycle. Then, evaluated against the new floor: pending[new] -> DOOR; else requests remain ahead in dir -> reload timer, stay MOVE; else -> IDLE, which handles reversal.
- DOOR: door_open=1; timer loaded DOOR_CYCLES-1. Reload on door_hold or req[floor]. At 0 with no reload -> IDLE.
- HALT: entered from any state while estop=1. Motors 0. door_open stays 1 only if entered from DOOR. Timer cleared. pending keeps latching. floor frozen; a partial travel is discarded. estop low -> IDLE.
- Boundaries: floor never decrements below 0 and never increments above N_FLOORS-1; the above/below logic guarantees this. req bits ≥ N_FLOORS do not exist. A simultaneous req and clr on the current floor in DOOR resolves to clr.

## Timing
- All outputs are registered from state and dir. motor_up = (MOVE & dir_up); motor_down = (MOVE & !dir_up).
- req sampled at edge E: pending visible after E. IDLE leaves at E+1, so the motor asserts after E+1 (2-cycle request-to-motor latency).
- Each floor step lasts exactly TRAVEL_CYCLES cycles in MOVE. arrive and the floor update occur on the same edge.
- Dwell is exactly DOOR_CYCLES cycles without extension. An extension restarts the full DOOR_CYCLES from the cycle after the hold/req.
- estop takes effect on the next edge, with priority over all transitions. Release -> IDLE on the next edge.

## Structure
- elevator_pkg holds:
  - the state enum (IDLE/MOVE/DOOR/HALT)
  - default constants for TRAVEL_CYCLES and DOOR_CYCLES
  - a helper function for the above/below masks
- Sub-module elevator_timer: loadable TIMER_W down-counter with load, clear and done; shared by MOVE and DOOR.

## Test plan
Common settings for all scenarios: N_FLOORS=8, TRAVEL_CYCLES=4, DOOR_CYCLES=3.
- Reset, then req=8'h08 -> motor_up after 2 cycles. arrive pulses at floors 1, 2, 3 every 4 cycles. door_open for 3 cycles at floor 3. pending=0, then IDLE.
- At floor 3 moving up, pending={1,6}: serves 6 before 1. dir_up flips to 0 only after floor 6 dwell.
- In DOOR at floor 2, assert door_hold for 5 cycles -> door_open lasts 5+3 cycles. req[2] mid-dwell -> dwell restarts, pending[2] stays 0.
- estop mid-travel from 0 to 4 -> motors 0 next edge, floor held. New req[7] latches. Release -> resumes from the held floor toward 4 then 7.
- Reset_n low mid-MOVE -> all outputs 0, floor 0, pending 0 immediately (asynchronous).
- req=8'h81 at floor 0 in IDLE -> door opens at floor 0 first, then travels to 7.
